dm_wb_cache: RTL and testbench
==============================

# dm_wb_cache

Parametrised direct-mapped, write-back, write-allocate cache that sits between the CPU data port and main memory. It generalises the single-word tag/valid/dirty store into a self-contained controller: multi-word lines, byte-enable writes, automatic dirty-line writeback and burst refill over a request/acknowledge memory port, and hit/miss performance counters.

## Interface
- `ADDR_W`, 32: word-address width.
- `SETS`, 64: number of lines, power of two, ≥ 2.
- `LINE_WORDS`, 4: 32-bit words per line, power of two, ≥ 1.
- Address split: offset = `cpu_addr[OFF-1:0]` (OFF = log2 LINE_WORDS), index = next log2 SETS bits, tag = remaining upper bits.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cpu_req` in 1: access request; held high with stable fields until `cpu_ready`.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W: word address.
- `cpu_wdata` in 32: write data.
- `cpu_wstrb` in 4: byte enables; bit i writes byte i.
- `cpu_rdata` out 32: read data, valid while `cpu_ready` is high.
- `cpu_ready` out 1: one-cycle completion pulse.
- `mem_req` out 1: memory beat request.
- `mem_we` out 1: 1 = writeback beat, 0 = refill beat.
- `mem_addr` out ADDR_W: beat word address.
- `mem_wdata` out 32: writeback data.
- `mem_rdata` in 32: refill data, sampled on `mem_ack`.
- `mem_ack` in 1: beat complete; ignored while `mem_req` is low.
- `hit_cnt` out 32: count of requests that hit on first lookup; wraps.
- `miss_cnt` out 32: count of requests that missed on first lookup; wraps.

## Operation
- Per-set state: `valid`, `dirty`, tag, and LINE_WORDS data words.
- FSM states:
  - IDLE: if `cpu_req` is high, latch addr/we/wdata/wstrb, clear `refilled` flag, go to LOOKUP.
  - LOOKUP: hit = valid & tag match.
    - Hit, read: latch word into `cpu_rdata`.
    - Hit, write: merge enabled bytes into the word and set `dirty`.
    - Hit (either): go to RESPOND.
    - Miss with victim valid & dirty: go to WRITEBACK.
    - Miss otherwise: go to REFILL.
    - If `refilled` = 0, increment `hit_cnt` or `miss_cnt`. The post-refill LOOKUP is never counted.
  - WRITEBACK: beat counter b = 0..LINE_WORDS-1. `mem_we`=1, `mem_addr` = {victim tag, index, b}, `mem_wdata` = victim word b. On `mem_ack` b increments; the last ack clears `dirty` and goes to REFILL.
  - REFILL: `mem_we`=0, `mem_addr` = {req tag, index, b}. On `mem_ack` write `mem_rdata` into word b. The last ack sets `valid`, writes the tag, clears `dirty`, sets `refilled`, and goes to LOOKUP (guaranteed hit).
  - RESPOND: `cpu_ready`=1 for one cycle, then IDLE. `cpu_req` is not sampled in RESPOND.
- Write miss allocates the line (refill first), then merges the write in LOOKUP.
- Data array is not reset. `valid` and `dirty` are cleared for all sets on reset.

## Timing
- Reset values:
  - `cpu_ready`, `mem_req`, `mem_we` = 0.
  - `cpu_rdata`, `mem_addr`, `mem_wdata` = 0.
  - `hit_cnt`, `miss_cnt` = 0.
  - FSM = IDLE, beat counter = 0, all `valid`/`dirty` = 0.
- Hit latency: `cpu_req` sampled at edge 0, LOOKUP during cycle 1, `cpu_ready` high in cycle 2. Maximum throughput is one access per 3 cycles.
- Miss latency: 3 + (dirty ? LINE_WORDS : 0) + LINE_WORDS beats + 1 (extra LOOKUP) cycles, plus memory wait cycles.
- `mem_req` stays high continuously across all beats of a writeback+refill sequence. `mem_addr`, `mem_we` and `mem_wdata` are held stable until acked and change in the cycle after an ack.
- `cpu_rdata` holds its last value outside `cpu_ready`.
- Reset mid-operation (any state, including mid-burst):
  - Aborts the access; the next cycle has `mem_req`=0 and `cpu_ready`=0.
  - Dirty data is discarded.
  - The aborted request gets no `cpu_ready`; the CPU must reissue it.
- Counter wrap: 0xFFFFFFFF + 1 = 0.

## Test plan
Tests use SETS=4, LINE_WORDS=2 (offset bit 0, index bits [2:1], tag [31:3]).
- After reset, read 0x10; memory returns 0xAAAA0000 and 0xAAAA0001 for refill beats 0x10 and 0x11 → no writeback beats, `cpu_rdata`=0xAAAA0000, `miss_cnt`=1, `hit_cnt`=0.
- Then read 0x11 → `cpu_ready` 2 cycles after request, `mem_req` stays 0, `cpu_rdata`=0xAAAA0001, `hit_cnt`=1.
- Write 0x10 with data 0x12345678, `cpu_wstrb`=4'b0011, then read 0x10 → `cpu_rdata`=0xAAAA5678, `hit_cnt`=3.
- Read 0x30 (same index, tag 6):
  - Writeback beats: `mem_we`=1 at 0x10 with data 0xAAAA5678, then 0x11 with 0xAAAA0001.
  - Refill beats: 0x30, 0x31.
  - `miss_cnt`=2.
- `mem_ack` delayed 5 cycles per beat → `mem_addr`/`mem_wdata` stable throughout, `cpu_ready` not asserted early.
- `rst` pulsed after the first refill ack of a miss → `mem_req`=0 and `cpu_ready`=0 the next cycle; rereading the same address misses again with a full refill.

Source files
------------

// File: rtl/dm_wb_cache_if.sv
// CPU data port and memory beat port of the direct-mapped write-back cache.
// The cache takes the slave view; the CPU/memory environment takes the master view.
interface dm_wb_cache_if #(
  parameter int ADDR_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_wstrb;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dm_wb_cache.sv
// Direct-mapped, write-back, write-allocate cache with byte-enable writes,
// burst writeback/refill over a req/ack memory port and hit/miss counters.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | wait for cpu_req, latch the request
// LOOKUP    | compare tag; hit completes, miss starts writeback or refill
// WRITEBACK | stream the dirty victim line out, one beat per mem_ack
// REFILL    | fetch the requested line, one beat per mem_ack
// RESPOND   | cpu_ready pulse, cpu_req ignored
module dm_wb_cache #(
  parameter int ADDR_W     = 32,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  dm_wb_cache_if.slave     bus,
  output logic [31:0]      hit_cnt,
  output logic [31:0]      miss_cnt
);
  localparam int OFF   = $clog2(LINE_WORDS);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OFF - IDX;
  localparam int BW    = (OFF > 0) ? OFF : 1;
  localparam int DA_W  = IDX + OFF;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL, S_RESPOND
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              refilled_q, refilled_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       hit_cnt_q, hit_cnt_d;
  logic [31:0]       miss_cnt_q, miss_cnt_d;
  logic [SETS-1:0]   valid_q, valid_d;
  logic [SETS-1:0]   dirty_q, dirty_d;

  // Data and tag arrays carry no reset; valid_q gates every use of them.
  logic [31:0]       data_mem [SETS*LINE_WORDS];
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic              data_we;
  logic [DA_W-1:0]   data_waddr;
  logic [31:0]       data_wdata;
  logic              tag_we;

  logic [IDX-1:0]    req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [BW-1:0]     req_off;
  logic [TAG_W-1:0]  vic_tag;
  logic [31:0]       cur_word;
  logic [31:0]       merged;
  logic [BW-1:0]     beat_nx;
  logic              hit;
  logic              ack;
  logic              last_beat;

  function automatic logic [DA_W-1:0] sel(input logic [IDX-1:0] i, input logic [BW-1:0] o);
    return (DA_W'(i) << OFF) | DA_W'(o);
  endfunction

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [TAG_W-1:0] t,
                                                  input logic [IDX-1:0] i,
                                                  input logic [BW-1:0] b);
    return (ADDR_W'(t) << (OFF + IDX)) | (ADDR_W'(i) << OFF) | ADDR_W'(b);
  endfunction

  assign req_idx   = IDX'(addr_q >> OFF);
  assign req_tag   = TAG_W'(addr_q >> (OFF + IDX));
  assign req_off   = BW'(addr_q & ADDR_W'(LINE_WORDS - 1));
  assign vic_tag   = tag_mem[req_idx];
  assign cur_word  = data_mem[sel(req_idx, req_off)];
  assign hit       = valid_q[req_idx] && (vic_tag == req_tag);
  assign beat_nx   = beat_q + 1'b1;
  assign last_beat = (beat_q == BW'(LINE_WORDS - 1));
  assign ack       = bus.mem_ack & mem_req_q;

  always_comb begin
    merged = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (wstrb_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    refilled_d  = refilled_q;
    beat_d      = beat_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ready_d = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    data_we     = 1'b0;
    data_waddr  = '0;
    data_wdata  = '0;
    tag_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req) begin
          addr_d     = bus.cpu_addr;
          we_d       = bus.cpu_we;
          wdata_d    = bus.cpu_wdata;
          wstrb_d    = bus.cpu_wstrb;
          refilled_d = 1'b0;
          state_d    = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        // The lookup that follows a refill is a guaranteed hit and not counted.
        if (!refilled_q) begin
          if (hit) hit_cnt_d  = hit_cnt_q + 32'd1;
          else     miss_cnt_d = miss_cnt_q + 32'd1;
        end
        if (hit) begin
          if (we_q) begin
            data_we          = 1'b1;
            data_waddr       = sel(req_idx, req_off);
            data_wdata       = merged;
            dirty_d[req_idx] = 1'b1;
          end else begin
            cpu_rdata_d = cur_word;
          end
          cpu_ready_d = 1'b1;
          state_d     = S_RESPOND;
        end else begin
          beat_d    = '0;
          mem_req_d = 1'b1;
          if (valid_q[req_idx] && dirty_q[req_idx]) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = beat_addr(vic_tag, req_idx, '0);
            mem_wdata_d = data_mem[sel(req_idx, '0)];
            state_d     = S_WRITEBACK;
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = beat_addr(req_tag, req_idx, '0);
            state_d    = S_REFILL;
          end
        end
      end
      S_WRITEBACK: begin
        if (ack) begin
          if (last_beat) begin
            beat_d           = '0;
            dirty_d[req_idx] = 1'b0;
            mem_we_d         = 1'b0;
            mem_addr_d       = beat_addr(req_tag, req_idx, '0);
            state_d          = S_REFILL;
          end else begin
            beat_d      = beat_nx;
            mem_addr_d  = beat_addr(vic_tag, req_idx, beat_nx);
            mem_wdata_d = data_mem[sel(req_idx, beat_nx)];
          end
        end
      end
      S_REFILL: begin
        if (ack) begin
          data_we    = 1'b1;
          data_waddr = sel(req_idx, beat_q);
          data_wdata = bus.mem_rdata;
          if (last_beat) begin
            beat_d           = '0;
            valid_d[req_idx] = 1'b1;
            dirty_d[req_idx] = 1'b0;
            tag_we           = 1'b1;
            refilled_d       = 1'b1;
            mem_req_d        = 1'b0;
            state_d          = S_LOOKUP;
          end else begin
            beat_d     = beat_nx;
            mem_addr_d = beat_addr(req_tag, req_idx, beat_nx);
          end
        end
      end
      S_RESPOND: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      refilled_q  <= 1'b0;
      beat_q      <= '0;
      cpu_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      refilled_q  <= refilled_d;
      beat_q      <= beat_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) data_mem[data_waddr] <= data_wdata;
    if (tag_we)  tag_mem[req_idx]     <= req_tag;
  end

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign hit_cnt       = hit_cnt_q;
  assign miss_cnt      = miss_cnt_q;
endmodule

// File: tb/tb_dm_wb_cache.sv
// Directed bench for dm_wb_cache (SETS=4, LINE_WORDS=2): CPU responses and
// memory beats are checked against expectation queues filled at issue time.
module tb_dm_wb_cache;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  dm_wb_cache_if #(.ADDR_W(32)) bus ();

  dm_wb_cache #(.ADDR_W(32), .SETS(4), .LINE_WORDS(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  typedef struct {
    logic        is_rd;
    logic [31:0] rdata;
    int          t0;
    int          lat;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  resp_t       rq[$];
  beat_t       bq[$];
  logic [31:0] mem_model [logic [31:0]];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          mem_delay = 0;
  logic        last_ack_we = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // CPU response monitor
  always @(negedge clk) begin
    resp_t e;
    if (bus.cpu_ready === 1'b1) begin
      if (rq.size() == 0) begin
        chk("unexpected_cpu_ready", 32'(bus.cpu_ready), 32'd0);
      end else begin
        e = rq.pop_front();
        if (e.is_rd) chk("cpu_rdata", bus.cpu_rdata, e.rdata);
        if (e.lat >= 0) chk("latency", 32'(cyc - e.t0), 32'(e.lat));
      end
    end
  end

  // Memory responder with programmable wait cycles per beat
  initial begin
    int          wcnt;
    beat_t       e;
    logic        cap_we;
    logic [31:0] cap_addr, cap_wdata;
    wcnt = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_req === 1'b1) begin
        if (wcnt == 0) begin
          cap_we    = bus.mem_we;
          cap_addr  = bus.mem_addr;
          cap_wdata = bus.mem_wdata;
          if (bq.size() == 0) begin
            chk("unexpected_mem_beat", bus.mem_addr, 32'hFFFF_FFFF);
          end else begin
            e = bq.pop_front();
            chk("beat_we", 32'(bus.mem_we), 32'(e.we));
            chk("beat_addr", bus.mem_addr, e.addr);
            if (e.we) chk("beat_wdata", bus.mem_wdata, e.wdata);
          end
        end else begin
          chk("hold_mem_we", 32'(bus.mem_we), 32'(cap_we));
          chk("hold_mem_addr", bus.mem_addr, cap_addr);
          if (cap_we) chk("hold_mem_wdata", bus.mem_wdata, cap_wdata);
        end
        if (wcnt >= mem_delay) begin
          bus.mem_ack = 1'b1;
          last_ack_we = bus.mem_we;
          if (bus.mem_we) mem_model[bus.mem_addr] = bus.mem_wdata;
          else bus.mem_rdata = mem_model.exists(bus.mem_addr) ? mem_model[bus.mem_addr]
                                                              : 32'hAAAA0000 + bus.mem_addr - 32'h10;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic exp_beat(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    beat_t b;
    b.we = we; b.addr = addr; b.wdata = wdata;
    bq.push_back(b);
  endtask

  // Called at a negedge; returns at a negedge with the DUT back in IDLE.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [31:0] exp_rdata, input int lat);
    resp_t e;
    int    got;
    e.is_rd = !we; e.rdata = exp_rdata; e.t0 = cyc; e.lat = lat;
    rq.push_back(e);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.cpu_wstrb = strb;
    got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.cpu_ready === 1'b1) begin
        got = 1;
        break;
      end
    end
    chk("cpu_ready_timeout", 32'(got), 32'd1);
    bus.cpu_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int got;
    rst           = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_wstrb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Clean read miss, then hits on the allocated line
    exp_beat(1'b0, 32'h10, '0);
    exp_beat(1'b0, 32'h11, '0);
    issue(1'b0, 32'h10, '0, 4'h0, 32'hAAAA0000, 5);
    chk("miss_cnt_a", miss_cnt, 32'd1);
    chk("hit_cnt_a", hit_cnt, 32'd0);
    issue(1'b0, 32'h11, '0, 4'h0, 32'hAAAA0001, 2);
    chk("hit_cnt_b", hit_cnt, 32'd1);
    issue(1'b1, 32'h10, 32'h12345678, 4'b0011, '0, 2);
    chk("rdata_hold", bus.cpu_rdata, 32'hAAAA0001);
    issue(1'b0, 32'h10, '0, 4'h0, 32'hAAAA5678, 2);
    chk("hit_cnt_c", hit_cnt, 32'd3);

    // Conflict miss on a dirty line: writeback then refill
    exp_beat(1'b1, 32'h10, 32'hAAAA5678);
    exp_beat(1'b1, 32'h11, 32'hAAAA0001);
    exp_beat(1'b0, 32'h30, '0);
    exp_beat(1'b0, 32'h31, '0);
    issue(1'b0, 32'h30, '0, 4'h0, 32'hAAAA0020, 7);
    chk("miss_cnt_b", miss_cnt, 32'd2);

    // Slow memory: 5 wait cycles per beat
    mem_delay = 5;
    exp_beat(1'b0, 32'h12, '0);
    exp_beat(1'b0, 32'h13, '0);
    issue(1'b0, 32'h12, '0, 4'h0, 32'hAAAA0002, 15);
    issue(1'b1, 32'h13, 32'hDEADBEEF, 4'b1111, '0, 2);
    exp_beat(1'b1, 32'h12, 32'hAAAA0002);
    exp_beat(1'b1, 32'h13, 32'hDEADBEEF);
    exp_beat(1'b0, 32'h32, '0);
    exp_beat(1'b0, 32'h33, '0);
    issue(1'b0, 32'h33, '0, 4'h0, 32'hAAAA0023, 27);
    chk("hit_cnt_d", hit_cnt, 32'd4);
    chk("miss_cnt_d", miss_cnt, 32'd4);

    // Reset after the first refill ack aborts the access
    mem_delay = 0;
    exp_beat(1'b0, 32'h20, '0);
    exp_beat(1'b0, 32'h21, '0);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h20;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (bus.mem_ack === 1'b1 && last_ack_we === 1'b0) begin
        got = 1;
        break;
      end
    end
    chk("abort_ack_timeout", 32'(got), 32'd1);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_mem_req", 32'(bus.mem_req), 32'd0);
    chk("abort_cpu_ready", 32'(bus.cpu_ready), 32'd0);
    chk("abort_hit_cnt", hit_cnt, 32'd0);
    rst = 1'b0;
    bus.cpu_req = 1'b0;
    repeat (2) @(negedge clk);

    exp_beat(1'b0, 32'h20, '0);
    exp_beat(1'b0, 32'h21, '0);
    issue(1'b0, 32'h20, '0, 4'h0, 32'hAAAA0010, 5);
    chk("post_rst_miss_cnt", miss_cnt, 32'd1);
    chk("post_rst_hit_cnt", hit_cnt, 32'd0);

    repeat (3) @(negedge clk);
    chk("resp_queue_empty", 32'(rq.size()), 32'd0);
    chk("beat_queue_empty", 32'(bq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end
endmodule
